hilo_muldiv: RTL
================

# hilo_muldiv

Parametrised HI/LO unit for the EX stage. Holds the HI/LO architectural pair and serves MTHI/MTLO writes, single-cycle MULT/MULTU, a multi-cycle iterative DIV/DIVU engine, and optional MADD/MSUB accumulation. It exposes `busy` so the pipeline can stall, and accepts `flush` to cancel an in-flight divide. Downstream forwarding reads `hi_o`/`lo_o` directly.

## Interface
- `WIDTH`, 32: HI, LO and operand width (≥ 4).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: cancels the in-flight divide and blocks acceptance this cycle.
- `op_valid` in 1: request strobe.
- `op` in 3: operation select.
  - 000 MTHI
  - 001 MTLO
  - 010 MULT
  - 011 MULTU
  - 100 DIV
  - 101 DIVU
  - 110 MADD
  - 111 MSUB
- `src_a` in WIDTH: rs operand / dividend / MTxx data.
- `src_b` in WIDTH: rt operand / divisor.
- `busy` out 1: divide in progress; requests are ignored.
- `done` out 1: one-cycle completion pulse.
- `div_by_zero` out 1: one-cycle pulse, coincident with `done`, for a zero-divisor divide.
- `hi_o` out WIDTH: HI register.
- `lo_o` out WIDTH: LO register.

## Operation
- **Acceptance.** A request is accepted at an edge where `op_valid && !busy && !flush && !rst`. A request that is not accepted is dropped; the requester holds it.
- **States.**
  - IDLE → DIV on acceptance of DIV/DIVU with `src_b != 0`.
  - DIV → IDLE after WIDTH iterations or on `flush`.
  - Every other op completes in IDLE.
- **MTHI / MTLO.** Write `src_a` to HI or LO; the other register is unchanged.
- **MULT / MULTU.** Full 2·WIDTH product, signed or unsigned. HI gets the upper half, LO the lower half.
- **MADD / MSUB.** Signed 2·WIDTH product, added to or subtracted from {HI,LO}. Wraps modulo 2^(2·WIDTH).
- **DIV / DIVU algorithm.** Restoring radix-2, one quotient bit per cycle, on operand magnitudes latched at acceptance. Signs are fixed up at completion.
- **DIV / DIVU results.**
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend.
  - Signed MIN/−1: LO = MIN, HI = 0.
- **Divide by zero.** No DIV state is entered. HI/LO are unchanged; `done` and `div_by_zero` pulse.
- **Flush during DIV.** Abort; HI/LO unchanged; no `done`.
- **Reset.** `rst` at any time, including mid-divide, forces all state to reset values:
  - `hi_o` = `lo_o` = 0
  - `busy` = `done` = `div_by_zero` = 0
  - state = IDLE, iteration counter = 0

## Timing
- **Acceptance edge.** Call it E0.
- **Single-cycle ops** (MTxx, MULT*, MADD/MSUB, divide-by-zero): HI/LO update at E0. `done` is high for the cycle after E0, with the new values visible on `hi_o`/`lo_o`.
- **DIV/DIVU busy window.** `busy` is high from after E0 through edge E_WIDTH, i.e. exactly WIDTH cycles.
- **DIV/DIVU writeback.** HI/LO are written at E_WIDTH. `done` pulses in the cycle after E_WIDTH, during which `busy` = 0.
- **Back-to-back issue.** A new request may be accepted in the same cycle `done` is high (back-to-back, no bubble).
- **Flush timing.** `flush` seen at edge Ek (1 ≤ k ≤ WIDTH) returns the unit to IDLE at Ek; `busy` is low the following cycle. A flush coincident with the final iteration edge wins: no write, no `done`.
- **Flush with a new request.** `flush` and `op_valid` in the same cycle: nothing is accepted.
- **Outputs.** `hi_o`/`lo_o` are registered outputs, with no combinational path from inputs.

## Configuration
- `HILO_MADD_EN` defined: ops 110/111 are implemented as above.
- `HILO_MADD_EN` undefined:
  - ops 110/111 are accepted but have no effect: HI/LO unchanged, no `done`;
  - the accumulate adder is not synthesised.

## Test plan
- **Reset.** Assert `rst` 2 cycles → `hi_o` = `lo_o` = 0, `busy` = `done` = 0. Then assert `rst` at iteration 5 of a DIVU → next cycle `busy` = 0, HI/LO = 0, no `done`.
- **Multiply.** MULT, a=0xFFFFFFFF, b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE, `done` next cycle. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Divide.**
  - DIV, a=−7 (0xFFFFFFF9), b=2 → `busy` exactly 32 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF, `done` 1 cycle.
  - DIVU, a=100, b=7 → LO=14, HI=2.
  - DIV, a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero and busy drop.**
  - DIV with b=0 → `done` = `div_by_zero` = 1 the cycle after acceptance, HI/LO unchanged, `busy` never asserted.
  - MTLO with 0x1234 issued while `busy` → ignored.
- **Flush.**
  - DIVU 100/7, `flush` at iteration 10 → `busy` low next cycle, no `done`, HI/LO keep their prior values.
  - MTHI 0xAAAA5555 in the following cycle → accepted, HI=0xAAAA5555.
- **Accumulate.**
  - HI=0, LO=0xFFFFFFFF, MADD a=1, b=1 → HI=1, LO=0. Then MSUB a=1, b=1 → HI=0, LO=0xFFFFFFFF.
  - With `HILO_MADD_EN` undefined: same stimulus → HI/LO unchanged, `done` stays 0.

Source files
------------

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: MTHI/MTLO, single-cycle MULT/MULTU, iterative restoring DIV/DIVU.
// Defining HILO_MADD_EN enables MADD/MSUB accumulation; otherwise ops 110/111 are accepted and do nothing.
module hilo_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, DIV} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   rem, quot, divisor;
    logic               neg_q, neg_r;
    logic [CW-1:0]      count;

    logic               accept, signed_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_next, quot_next, q_fix, r_fix;
    logic [2*WIDTH-1:0] prod_s, prod_u;

    assign accept     = op_valid && !busy && !flush;
    assign signed_div = ~op[0];
    assign a_neg      = signed_div & src_a[WIDTH-1];
    assign b_neg      = signed_div & src_b[WIDTH-1];
    assign a_mag      = a_neg ? -src_a : src_a;
    assign b_mag      = b_neg ? -src_b : src_b;

    // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
    assign prod_s = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_u = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    always_comb begin
        trial = {rem, quot[WIDTH-1]} - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = {rem[WIDTH-2:0], quot[WIDTH-1]};
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
        q_fix = neg_q ? -quot_next : quot_next;
        r_fix = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            rem         <= '0;
            quot        <= '0;
            divisor     <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b000: begin
                                hi   <= src_a;
                                done <= 1'b1;
                            end
                            3'b001: begin
                                lo   <= src_a;
                                done <= 1'b1;
                            end
                            3'b010: begin
                                {hi, lo} <= prod_s;
                                done     <= 1'b1;
                            end
                            3'b011: begin
                                {hi, lo} <= prod_u;
                                done     <= 1'b1;
                            end
                            3'b100, 3'b101: begin
                                if (src_b == '0) begin
                                    done        <= 1'b1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    state   <= DIV;
                                    busy    <= 1'b1;
                                    count   <= '0;
                                    rem     <= '0;
                                    quot    <= a_mag;
                                    divisor <= b_mag;
                                    neg_q   <= a_neg ^ b_neg;
                                    neg_r   <= a_neg;
                                end
                            end
                            default: begin
`ifdef HILO_MADD_EN
                                if (op[0])
                                    {hi, lo} <= {hi, lo} - prod_s;
                                else
                                    {hi, lo} <= {hi, lo} + prod_s;
                                done <= 1'b1;
`endif
                            end
                        endcase
                    end
                end
                DIV: begin
                    // Flush outranks the final iteration, so an aborted divide never writes back.
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == LAST) begin
                        hi    <= r_fix;
                        lo    <= q_fix;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        rem   <= rem_next;
                        quot  <= quot_next;
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign hi_o = hi;
    assign lo_o = lo;

endmodule
